// File: rtl/edf_irq_ctrl.sv
// Earliest-deadline-first interrupt controller core.
// Each irq line captures rising edges. A captured edge stamps an absolute deadline
// taken from the local time base. The line with the least signed slack is offered
// to the hart over a valid/ready claim. One claimed irq is tracked until it completes.
module edf_irq_ctrl #(
    parameter int NrInputs  = 32,
    parameter int PrioWidth = 8,
    localparam int IdxWidth = $clog2(NrInputs)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          tick_i,
    input  logic [NrInputs-1:0]           irq_i,
    input  logic [NrInputs-1:0]           ie_i,
    input  logic [NrInputs*PrioWidth-1:0] reldl_i,
    output logic                          irq_valid_o,
    input  logic                          irq_ready_i,
    output logic [IdxWidth-1:0]           irq_id_o,
    output logic [PrioWidth-1:0]          irq_slack_o,
    input  logic                          cpl_valid_i,
    input  logic [IdxWidth-1:0]           cpl_id_i,
    output logic                          miss_o,
    output logic                          cpl_err_o
);

    localparam logic signed [PrioWidth-1:0] MostNeg = {1'b1, {(PrioWidth-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    // A line that has missed its deadline competes with the most urgent possible slack
    function automatic logic signed [PrioWidth-1:0] arb_prio_f(
        input logic signed [PrioWidth-1:0] slack,
        input logic                        missed
    );
        return missed ? MostNeg : slack;
    endfunction

    state_e                        state_q, state_d;
    logic [PrioWidth-1:0]          time_q;
    logic [NrInputs-1:0]           irq_q;
    logic [NrInputs-1:0]           pending_q, pending_d;
    logic [NrInputs-1:0]           miss_q, miss_d;
    logic [PrioWidth-1:0]          dl_q [NrInputs];
    logic signed [PrioWidth-1:0]   slack [NrInputs];
    logic signed [PrioWidth-1:0]   arb_in [NrInputs];
    logic [NrInputs-1:0]           slack_neg;
    logic [NrInputs-1:0]           rise, claim_vec, load_vec, arb_req;
    logic                          claim;
    logic                          arb_valid;
    logic [IdxWidth-1:0]           arb_idx;
    logic signed [PrioWidth-1:0]   arb_prio;
    logic                          latch;
    logic                          irq_valid_q, irq_valid_d;
    logic [IdxWidth-1:0]           id_q, active_q;
    logic signed [PrioWidth-1:0]   slack_q;
    logic                          cpl_err_q, cpl_err_d;

    assign claim = irq_valid_q & irq_ready_i;

    // Per-line slack against the current time and the value seen by the arbiter
    always_comb begin
        for (int i = 0; i < NrInputs; i++) begin
            slack[i]     = dl_q[i] - time_q;
            slack_neg[i] = slack[i][PrioWidth-1];
            arb_in[i]    = arb_prio_f(slack[i], miss_q[i]);
        end
    end

    // Capture, claim and miss bookkeeping; a claim re-arms its line so a coincident edge reloads it
    always_comb begin
        rise      = irq_i & ~irq_q;
        claim_vec = '0;
        if (claim) begin
            claim_vec[id_q] = 1'b1;
        end
        load_vec  = rise & (~pending_q | claim_vec);
        pending_d = (pending_q & ~claim_vec) | load_vec;
        miss_d    = (miss_q | (pending_q & slack_neg)) & ~claim_vec;
        arb_req   = pending_q & ie_i;
    end

    // Smallest signed slack wins; scanning upward with a strict compare favours the lower index
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        arb_prio  = '0;
        for (int i = 0; i < NrInputs; i++) begin
            if (arb_req[i] && (!arb_valid || (arb_in[i] < arb_prio))) begin
                arb_valid = 1'b1;
                arb_idx   = IdxWidth'(i);
                arb_prio  = arb_in[i];
            end
        end
    end

    // Offer/service sequencing and completion checking
    always_comb begin
        state_d     = state_q;
        latch       = 1'b0;
        irq_valid_d = 1'b0;
        cpl_err_d   = cpl_valid_i && !((state_q == ACTIVE) && (cpl_id_i == active_q));
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    latch   = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (claim) begin
                    state_d = ACTIVE;
                end else begin
                    irq_valid_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (cpl_valid_i && (cpl_id_i == active_q)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Time base and per-line pending/deadline/miss state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            time_q    <= '0;
            irq_q     <= '0;
            pending_q <= '0;
            miss_q    <= '0;
            for (int i = 0; i < NrInputs; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            if (tick_i) begin
                time_q <= time_q + 1'b1;
            end
            irq_q     <= irq_i;
            pending_q <= pending_d;
            miss_q    <= miss_d;
            for (int i = 0; i < NrInputs; i++) begin
                if (load_vec[i]) begin
                    dl_q[i] <= time_q + reldl_i[i*PrioWidth +: PrioWidth];
                end
            end
        end
    end

    // State register, registered offer outputs and in-service id
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            irq_valid_q <= 1'b0;
            id_q        <= '0;
            slack_q     <= '0;
            active_q    <= '0;
            cpl_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            irq_valid_q <= irq_valid_d;
            cpl_err_q   <= cpl_err_d;
            if (latch) begin
                id_q    <= arb_idx;
                slack_q <= arb_prio;
            end
            if (claim) begin
                active_q <= id_q;
            end
        end
    end

    assign irq_valid_o = irq_valid_q;
    assign irq_id_o    = id_q;
    assign irq_slack_o = slack_q;
    assign miss_o      = |miss_q;
    assign cpl_err_o   = cpl_err_q;

endmodule

// File: tb/tb_edf_irq_ctrl.sv
// Self-checking bench for edf_irq_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural EDF model.
module tb_edf_irq_ctrl;

    localparam int N    = 16;
    localparam int PW   = 8;
    localparam int IW   = $clog2(N);
    localparam int MASK = (1 << PW) - 1;
    localparam int HALF = 1 << (PW - 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              tick = 1'b0;
    logic [N-1:0]      irq = '0;
    logic [N-1:0]      ie = '1;
    logic [N*PW-1:0]   reldl = '0;
    logic              irq_valid;
    logic              irq_ready = 1'b0;
    logic [IW-1:0]     irq_id;
    logic [PW-1:0]     irq_slack;
    logic              cpl_valid = 1'b0;
    logic [IW-1:0]     cpl_id = '0;
    logic              miss;
    logic              cpl_err;

    int n_checks = 0;
    int n_errors = 0;

    edf_irq_ctrl #(.NrInputs(N), .PrioWidth(PW)) dut (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .irq_i(irq), .ie_i(ie),
        .reldl_i(reldl), .irq_valid_o(irq_valid), .irq_ready_i(irq_ready),
        .irq_id_o(irq_id), .irq_slack_o(irq_slack), .cpl_valid_i(cpl_valid),
        .cpl_id_i(cpl_id), .miss_o(miss), .cpl_err_o(cpl_err)
    );

    always #5 clk = ~clk;

    // Reference model: time in plain integers, deadlines as absolute times
    int m_time;
    bit m_pend [N];
    int m_dl   [N];
    bit m_miss [N];
    bit m_prev [N];
    int m_phase;   // 0 waiting for a winner, 1 winner chosen, 2 offered, 3 in service
    int m_active;
    bit exp_valid, exp_miss, exp_err;
    int exp_id, exp_slack;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_slack(int i);
        int s = (m_dl[i] - m_time) & MASK;
        return (s >= HALF) ? s - (1 << PW) : s;
    endfunction

    function automatic int m_eff(int i);
        return m_miss[i] ? -HALF : m_slack(i);
    endfunction

    function automatic int get_rel(int i);
        logic [PW-1:0] v = reldl[i*PW +: PW];
        return int'(v);
    endfunction

    task automatic model_reset();
        m_time = 0; m_phase = 0; m_active = 0;
        exp_valid = 0; exp_miss = 0; exp_err = 0; exp_id = 0; exp_slack = 0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_dl[i] = 0; m_miss[i] = 0; m_prev[i] = 0;
        end
    endtask

    // One clock edge of the model, using the inputs present at that edge
    task automatic model_step();
        bit claim, found, claim_i, rise;
        int w, best;
        bit npend [N];
        bit nmiss [N];
        int ndl   [N];
        if (rst) begin
            model_reset();
            return;
        end
        claim = exp_valid && irq_ready;
        found = 0; w = 0; best = 0;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && ie[i] && (!found || m_eff(i) < best)) begin
                found = 1; w = i; best = m_eff(i);
            end
        end
        exp_err = cpl_valid && !(m_phase == 3 && int'(cpl_id) == m_active);
        exp_miss = 0;
        for (int i = 0; i < N; i++) begin
            claim_i  = claim && (exp_id == i);
            rise     = irq[i] && !m_prev[i];
            nmiss[i] = (m_miss[i] || (m_pend[i] && m_slack(i) < 0)) && !claim_i;
            npend[i] = m_pend[i] && !claim_i;
            ndl[i]   = m_dl[i];
            if (rise && (!m_pend[i] || claim_i)) begin
                npend[i] = 1;
                ndl[i]   = (m_time + get_rel(i)) & MASK;
            end
            exp_miss |= nmiss[i];
        end
        case (m_phase)
            0: if (found) begin exp_id = w; exp_slack = best; m_phase = 1; end
            1: begin exp_valid = 1; m_phase = 2; end
            2: if (claim) begin exp_valid = 0; m_active = exp_id; m_phase = 3; end
            default: if (cpl_valid && int'(cpl_id) == m_active) m_phase = 0;
        endcase
        for (int i = 0; i < N; i++) begin
            m_pend[i] = npend[i]; m_miss[i] = nmiss[i]; m_dl[i] = ndl[i];
            m_prev[i] = irq[i];
        end
        m_time = (m_time + (tick ? 1 : 0)) & MASK;
    endtask

    task automatic compare_all();
        check_val("valid", 32'(irq_valid), 32'(exp_valid));
        check_val("id", 32'(irq_id), 32'(exp_id));
        check_val("slack", 32'(irq_slack), 32'(exp_slack & MASK));
        check_val("miss", 32'(miss), 32'(exp_miss));
        check_val("cpl_err", 32'(cpl_err), 32'(exp_err));
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        cycle();
        rst = 1'b0;
    endtask

    task automatic set_rel(input int i, input int v);
        reldl[i*PW +: PW] = PW'(v);
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 20 && !irq_valid; k++) cycle();
        check_val("wait_valid", 32'(irq_valid), 32'd1);
    endtask

    task automatic serve(input int id);
        wait_valid();
        check_val("serve_id", 32'(irq_id), 32'(id));
        irq_ready = 1'b1; cycle(); irq_ready = 1'b0;
        check_val("claimed_valid", 32'(irq_valid), 32'd0);
        cpl_valid = 1'b1; cpl_id = IW'(id); cycle(); cpl_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Single line, offer two edges after capture
        set_rel(3, 10); irq[3] = 1'b1; cycle(); irq[3] = 1'b0;
        cycle(); cycle();
        check_val("t1_valid", 32'(irq_valid), 32'd1);
        check_val("t1_id", 32'(irq_id), 32'd3);
        check_val("t1_slack", 32'(irq_slack), 32'd10);
        irq_ready = 1'b1; cycle(); irq_ready = 1'b0;
        cpl_valid = 1'b1; cpl_id = IW'(3); cycle(); cpl_valid = 1'b0;

        // Earlier deadline first
        set_rel(5, 20); set_rel(9, 7); irq[5] = 1'b1; irq[9] = 1'b1; cycle(); irq = '0;
        serve(9); serve(5);

        // Tie resolved to lower index
        set_rel(2, 4); set_rel(6, 4); irq[2] = 1'b1; irq[6] = 1'b1; cycle(); irq = '0;
        serve(2); serve(6);

        // Deadline miss: missed line beats a line with zero slack
        ie = '0; tick = 1'b1; set_rel(1, 3); irq[1] = 1'b1; cycle(); irq = '0;
        for (int k = 0; k < 7; k++) cycle();
        check_val("t4_miss", 32'(miss), 32'd1);
        tick = 1'b0; set_rel(0, 0); irq[0] = 1'b1; cycle(); irq = '0;
        ie = '1;
        wait_valid();
        check_val("t4_id", 32'(irq_id), 32'd1);
        check_val("t4_slack", 32'(irq_slack), 32'h80);
        serve(1);
        check_val("t4_miss_clr", 32'(miss), 32'd0);
        serve(0);

        // Time wrap ordering
        ie = '0; tick = 1'b1;
        for (int k = (250 - m_time) & MASK; k > 0; k--) cycle();
        set_rel(4, 10); set_rel(7, 12); irq[4] = 1'b1; irq[7] = 1'b1; cycle(); irq = '0;
        for (int k = 0; k < 7; k++) cycle();
        tick = 1'b0; ie = '1;
        wait_valid();
        check_val("t5_id", 32'(irq_id), 32'd4);
        check_val("t5_slack", 32'(irq_slack), 32'd2);
        serve(4); serve(7);

        // Wrong completion id, then reset while offering
        set_rel(3, 10); irq[3] = 1'b1; cycle(); irq = '0;
        wait_valid();
        irq_ready = 1'b1; cycle(); irq_ready = 1'b0;
        cpl_valid = 1'b1; cpl_id = IW'(7); cycle(); cpl_valid = 1'b0;
        check_val("t6_err", 32'(cpl_err), 32'd1);
        cycle();
        check_val("t6_err_pulse", 32'(cpl_err), 32'd0);
        cpl_valid = 1'b1; cpl_id = IW'(3); cycle(); cpl_valid = 1'b0;
        irq[3] = 1'b1; cycle(); irq = '0;
        wait_valid();
        rst = 1'b1; #1;
        check_val("t6_rst_valid", 32'(irq_valid), 32'd0);
        model_reset();
        cycle(); rst = 1'b0;
        for (int k = 0; k < 4; k++) cycle();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            irq  = N'($urandom & $urandom & $urandom);
            ie   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
            tick = $urandom_range(0, 1) == 1;
            irq_ready = $urandom_range(0, 2) == 0;
            cpl_valid = $urandom_range(0, 3) == 0;
            cpl_id = ($urandom_range(0, 3) != 0) ? IW'(m_active) : IW'($urandom_range(0, N - 1));
            for (int i = 0; i < N; i++) set_rel(i, $urandom_range(0, HALF - 1));
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
